// File: rtl/rv32i_wb_pkg.sv
// Shared types and helpers for the integer register-file writeback path.
// Holds the register-file geometry and the write-request bundle.
package rv32i_wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic is_x0(
    input logic [ADDR_W-1:0] idx
  );
    return idx == '0;
  endfunction

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// Small FIFO holding load results waiting for a free write port.
// Depth must be a power of two so the pointers wrap naturally.
module wb_fifo
  import rv32i_wb_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t wr,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(Depth);

  wb_req_t        mem [Depth];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [PW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = count == (PW+1)'(Depth);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port arbiter (ALU over buffered loads)
// with a per-register busy scoreboard for issue hazards.
module regfile_writeback
  import rv32i_wb_pkg::*;
#(
  parameter int Data_Width   = DATA_W,
  parameter int AddrRegWidth = ADDR_W,
  parameter int LdFifoDepth  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [AddrRegWidth-1:0]    issue_rd,
  input  logic [AddrRegWidth-1:0]    issue_rs1,
  input  logic [AddrRegWidth-1:0]    issue_rs2,
  output logic                       issue_ready,
  input  logic                       alu_valid,
  input  logic [AddrRegWidth-1:0]    alu_rd,
  input  logic [Data_Width-1:0]      alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [AddrRegWidth-1:0]    ld_rd,
  input  logic [Data_Width-1:0]      ld_data,
  output logic                       wb_en,
  output logic [AddrRegWidth-1:0]    wb_rd,
  output logic [Data_Width-1:0]      wb_data,
  output logic [2**AddrRegWidth-1:0] busy
);

  localparam int NR = 2 ** AddrRegWidth;

  wb_req_t                 ld_req;
  wb_req_t                 ld_head;
  logic                    ld_push;
  logic                    ld_pop;
  logic                    ld_full;
  logic                    ld_empty;
  logic                    alu_sel;
  logic                    hazard;
  logic                    issue_fire;
  logic                    wb_en_q;
  logic [AddrRegWidth-1:0] wb_rd_q;
  logic [Data_Width-1:0]   wb_data_q;
  logic [NR-1:0]           busy_q;
  logic [NR-1:0]           busy_d;

  always_comb begin
    hazard = 1'b0;
    if (!is_x0(issue_rs1) && busy_q[issue_rs1]) hazard = 1'b1;
    if (!is_x0(issue_rs2) && busy_q[issue_rs2]) hazard = 1'b1;
    if (!is_x0(issue_rd)  && busy_q[issue_rd])  hazard = 1'b1;
  end

  assign issue_ready = !hazard;
  assign issue_fire  = issue_valid && issue_ready;

  // x0 loads complete the handshake but never occupy the buffer
  assign ld_ready = !ld_full;
  assign ld_push  = ld_valid && !ld_full && !is_x0(ld_rd);
  assign alu_sel  = alu_valid && !is_x0(alu_rd);
  assign ld_pop   = !alu_sel && !ld_empty;

  always_comb begin
    ld_req      = '0;
    ld_req.rd   = ld_rd;
    ld_req.data = ld_data;
  end

  wb_fifo #(
    .Depth (LdFifoDepth)
  ) u_ld_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ld_push),
    .wr    (ld_req),
    .pop   (ld_pop),
    .head  (ld_head),
    .full  (ld_full),
    .empty (ld_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q <= alu_sel || ld_pop;
      if (alu_sel) begin
        wb_rd_q   <= alu_rd;
        wb_data_q <= alu_data;
      end else if (ld_pop) begin
        wb_rd_q   <= ld_head.rd;
        wb_data_q <= ld_head.data;
      end
    end
  end

  // clear first so a same-edge re-issue to the same rd keeps it busy
  always_comb begin
    busy_d = busy_q;
    if (wb_en_q) begin
      busy_d[wb_rd_q] = 1'b0;
    end
    if (issue_fire && !is_x0(issue_rd)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a write-order scoreboard.
// A small arbitration model predicts every register-file write.
module tb_regfile_writeback;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] busy;

  int vectors;
  int miscompares;

  logic [36:0] sb[$];
  logic [36:0] ld_pend[$];

  regfile_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_ready (issue_ready),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arbitration model: ALU first, else oldest buffered load.
  task automatic model_cycle();
    bit room;
    room = ld_pend.size() < 2;
    if (alu_valid && alu_rd != 5'd0) begin
      sb.push_back({alu_rd, alu_data});
    end else if (ld_pend.size() != 0) begin
      sb.push_back(ld_pend.pop_front());
    end
    if (ld_valid && room && ld_rd != 5'd0) begin
      ld_pend.push_back({ld_rd, ld_data});
    end
  endtask

  task automatic tick();
    if (rst) model_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && wb_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected_rd", {59'd0, wb_rd}, 64'h1_0000_0000);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("wb_rd", {59'd0, wb_rd}, {59'd0, e[36:32]});
        chk("wb_data", {32'd0, wb_data}, {32'd0, e[31:0]});
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_rs1   = '0;
    issue_rs2   = '0;
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    ld_valid    = 1'b0;
    ld_rd       = '0;
    ld_data     = '0;

    // reset state
    #3;
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_issue_ready", issue_ready, 1);
    #9 rst = 1'b1;
    tick();

    // ALU write, one-cycle latency
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    chk("alu_busy_before", busy, 0);
    tick();
    alu_valid = 1'b0;
    chk("alu_wb_en", wb_en, 1);
    chk("alu_wb_rd", wb_rd, 5);
    chk("alu_wb_data", wb_data, 32'hDEADBEEF);
    tick();
    chk("alu_wb_en_off", wb_en, 0);
    chk("alu_busy_after", busy, 0);

    // RAW stall released by a load
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    chk("raw_first_ready", issue_ready, 1);
    tick();
    issue_rd  = 5'd0;
    issue_rs1 = 5'd7;
    chk("raw_busy7", busy, 32'h0000_0080);
    chk("raw_stall0", issue_ready, 0);
    tick();
    chk("raw_stall1", issue_ready, 0);
    tick();
    ld_valid = 1'b1;
    ld_rd    = 5'd7;
    ld_data  = 32'h1234_5677;
    chk("raw_ld_ready", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
    chk("raw_stall2", issue_ready, 0);
    chk("raw_no_wb_yet", wb_en, 0);
    tick();
    chk("raw_ld_wb_en", wb_en, 1);
    chk("raw_ld_wb_rd", wb_rd, 7);
    chk("raw_stall_wb_cycle", issue_ready, 0);
    tick();
    chk("raw_released", issue_ready, 1);
    chk("raw_busy_clear", busy, 0);
    tick();
    issue_valid = 1'b0;
    issue_rs1   = 5'd0;

    // ALU priority and load back-pressure
    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    alu_data  = 32'd100;
    ld_valid  = 1'b1;
    ld_rd     = 5'd8;
    ld_data   = 32'hA8;
    chk("pri_ready0", ld_ready, 1);
    tick();
    alu_data = 32'd101;
    ld_rd    = 5'd9;
    ld_data  = 32'hA9;
    chk("pri_ready1", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
    alu_data = 32'd102;
    chk("pri_full2", ld_ready, 0);
    tick();
    alu_data = 32'd103;
    chk("pri_full3", ld_ready, 0);
    tick();
    chk("pri_alu_rd", wb_rd, 3);
    chk("pri_alu_data", wb_data, 103);
    alu_valid = 1'b0;
    tick();
    chk("pri_ld8", wb_rd, 8);
    chk("pri_ready_after_pop", ld_ready, 1);
    tick();
    chk("pri_ld9", wb_rd, 9);
    chk("pri_ld9_data", wb_data, 32'hA9);
    tick();
    chk("pri_idle", wb_en, 0);

    // x0 writes are dropped
    alu_valid   = 1'b1;
    alu_rd      = 5'd0;
    alu_data    = 32'hFF;
    ld_valid    = 1'b1;
    ld_rd       = 5'd0;
    ld_data     = 32'hEE;
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    chk("x0_ld_ready", ld_ready, 1);
    tick();
    chk("x0_wb_en", wb_en, 0);
    chk("x0_ld_ready_after", ld_ready, 1);
    chk("x0_busy", busy, 0);
    alu_valid   = 1'b0;
    ld_valid    = 1'b0;
    issue_valid = 1'b0;
    tick();
    chk("x0_wb_en2", wb_en, 0);

    // WAW on x4
    issue_valid = 1'b1;
    issue_rd    = 5'd4;
    chk("waw_first", issue_ready, 1);
    tick();
    chk("waw_busy4", busy, 32'h0000_0010);
    chk("waw_stall", issue_ready, 0);
    alu_valid = 1'b1;
    alu_rd    = 5'd4;
    alu_data  = 32'h44;
    tick();
    alu_valid = 1'b0;
    chk("waw_wb_rd", wb_rd, 4);
    chk("waw_stall_wb", issue_ready, 0);
    tick();
    chk("waw_released", issue_ready, 1);
    chk("waw_busy_clear", busy, 0);
    tick();
    issue_valid = 1'b0;
    chk("waw_second_busy", busy, 32'h0000_0010);
    alu_valid = 1'b1;
    alu_data  = 32'h45;
    tick();
    alu_valid = 1'b0;
    tick();
    chk("waw_final_busy", busy, 0);

    // asynchronous reset with loads buffered and x10 in flight
    issue_valid = 1'b1;
    issue_rd    = 5'd10;
    tick();
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_rd      = 5'd3;
    alu_data    = 32'h33;
    ld_valid    = 1'b1;
    ld_rd       = 5'd11;
    ld_data     = 32'hB11;
    tick();
    alu_data = 32'h34;
    ld_rd    = 5'd12;
    ld_data  = 32'hB12;
    tick();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    chk("ar_full", ld_ready, 0);
    chk("ar_busy10", busy, 32'h0000_0400);
    #1 rst = 1'b0;
    sb.delete();
    ld_pend.delete();
    #1;
    chk("ar_wb_en", wb_en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ld_ready", ld_ready, 1);
    chk("ar_wb_rd", wb_rd, 0);
    #5 rst = 1'b1;
    tick();
    chk("ar_no_stale0", wb_en, 0);
    tick();
    chk("ar_no_stale1", wb_en, 0);
    tick();
    chk("ar_issue_ready", issue_ready, 1);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side controller for the 32-entry integer register file.
- Drives the file's write port (en, rd, data) from two sources:
  - the single-cycle ALU result;
  - the multi-cycle load unit, via a valid/ready handshake and a small buffer.
- Keeps a busy scoreboard per architectural register, so issue logic stalls on RAW/WAW hazards against writes still in flight.
- Sits between execute/memory stages and the register file. Its wb_* outputs connect directly to register_file en/rd/data.

Parameters:
- Data_Width, 32, register/data width in bits.
- AddrRegWidth, 5, register index width (2**AddrRegWidth registers).
- LdFifoDepth, 2, load-result buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- issue_valid  input  1  instruction presented for issue.
- issue_rd  input  AddrRegWidth  destination of issuing instruction.
- issue_rs1  input  AddrRegWidth  source 1 of issuing instruction.
- issue_rs2  input  AddrRegWidth  source 2 of issuing instruction.
- issue_ready  output  1  issue accepted this cycle (no hazard).
- alu_valid  input  1  ALU result valid; always accepted, no ready.
- alu_rd  input  AddrRegWidth  ALU destination register.
- alu_data  input  Data_Width  ALU result.
- ld_valid  input  1  load result valid.
- ld_ready  output  1  load result accepted (buffer not full).
- ld_rd  input  AddrRegWidth  load destination register.
- ld_data  input  Data_Width  load data.
- wb_en  output  1  register-file write enable (registered).
- wb_rd  output  AddrRegWidth  register-file write index (registered).
- wb_data  output  Data_Width  register-file write data (registered).
- busy  output  2**AddrRegWidth  scoreboard vector; bit 0 is always 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - wb_en=0, wb_rd=0, wb_data=0.
  - busy=0.
  - Load buffer empty, so ld_ready=1 combinationally.
- Hazard (combinational): hazard = busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd], indexing only nonzero registers; index 0 never hazards.
- issue_ready = !hazard, independent of issue_valid.
- Issue fires when issue_valid && issue_ready. At the next edge, busy[issue_rd] is set if issue_rd != 0.
- Load handshake:
  - Fires when ld_valid && ld_ready; entry {ld_rd, ld_data} is pushed at the edge.
  - ld_ready = !full.
  - ld_rd=0 entries are accepted and discarded (not pushed).
- Writeback selection, per cycle, one write only:
  - if alu_valid && alu_rd!=0, select the ALU;
  - else if the buffer is non-empty, pop its head;
  - else nothing is selected.
  - The ALU always has priority. Loads wait in the buffer; the load unit is back-pressured when the buffer is full.
- wb_* update at the edge from the selection:
  - wb_en=1 when something is selected, else 0.
  - wb_rd/wb_data are loaded only when selected, otherwise held.
- Latency:
  - ALU result to wb_en: 1 cycle.
  - Load accepted into an empty buffer to wb_en: 2 cycles, if no ALU conflict.
- Busy clear: when wb_en=1, busy[wb_rd] is cleared at the same edge the register file captures the write. A dependent instruction can issue the cycle after and reads the new value.
- Simultaneous set and clear of the same index at one edge: set wins.
- Simultaneous push and pop on a full buffer: not allowed, because ld_ready=0 when full.
- Simultaneous push and pop on a non-full buffer: both occur and the count is unchanged.
- Buffer pointers wrap modulo LdFifoDepth.
- A write to x0 never asserts wb_en and never sets busy.
- Reset mid-operation: all buffered loads and in-flight busy bits are dropped. Upstream must also be flushed.

Decomposition:
- Package rv32i_wb_pkg holds:
  - NUM_REGS = 2**AddrRegWidth;
  - typedef wb_req_t = struct {rd, data};
  - function is_x0(idx).
- One sub-module, wb_fifo:
  - parameterized depth, carries wb_req_t;
  - push/pop/full/empty;
  - same clk/rst convention.
- Scoreboard and arbitration stay in regfile_writeback.

Test Plan:
- Reset and ALU write: assert rst=0 then release; alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF for one cycle -> next cycle wb_en=1, wb_rd=5, wb_data=DEADBEEF; busy stays 0 before and after.
- RAW stall: issue rd=7, then issue rs1=7; load returns rd=7 after 3 cycles -> issue_ready=0 until the cycle after wb_en with wb_rd=7, then 1.
- Priority and back-pressure: hold alu_valid=1 (rd=3) for 4 cycles while pushing loads rd=8 and rd=9 -> ld_ready=0 after 2 pushes. Once alu_valid drops, wb_rd=8 then 9 on consecutive cycles.
- x0 handling: alu_rd=0 and a load with ld_rd=0 -> wb_en stays 0, busy=0, ld_ready stays 1.
- WAW: issue rd=4 twice back-to-back -> second issue_ready=0 until the first write clears busy[4].
- Async reset mid-flight: buffer holds 2 entries and busy[10]=1; pulse rst=0 between clock edges -> wb_en=0, busy=0, ld_ready=1 immediately, and no stale writes afterwards.
